// File: rtl/led_regs_pkg.sv
// Register offsets, response codes and FSM state types shared by the LED
// controller register block.
package led_regs_pkg;

   localparam logic [7:0] OFF_CTRL    = 8'h00;
   localparam logic [7:0] OFF_INTCLR  = 8'h04;
   localparam logic [7:0] OFF_INTCNT  = 8'h08;
   localparam logic [7:0] OFF_STATUS  = 8'h0C;
   localparam logic [7:0] OFF_SCRATCH = 8'h10;
   localparam logic [7:0] OFF_ID      = 8'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/led_ctrl_regs.sv
// AXI4-Lite register slave for the LED counter: divider control, interrupt
// clear pulse, status/count readback, scratch and ID registers.
module led_ctrl_regs
   import led_regs_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter logic [31:0] BLK_ID = 32'h4C45_4431
) (
   input  logic              clk100,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [11:0]       div_o,
   output logic              wren_o,
   output logic              int_clr_o,
   input  logic [31:0]       int_cnt_i,
   input  logic              led_i,
   input  logic              led_int_i
);

   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(OFF_CTRL    >> 2);
   localparam logic [IDX_W-1:0] IDX_INTCLR  = IDX_W'(OFF_INTCLR  >> 2);
   localparam logic [IDX_W-1:0] IDX_INTCNT  = IDX_W'(OFF_INTCNT  >> 2);
   localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(OFF_STATUS  >> 2);
   localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(OFF_SCRATCH >> 2);
   localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(OFF_ID      >> 2);

   w_state_e         w_state_q, w_state_d;
   r_state_e         r_state_q, r_state_d;
   logic             aw_held_q, aw_held_d;
   logic             w_held_q, w_held_d;
   logic [IDX_W-1:0] awidx_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [11:0]      div_q, div_d;
   logic [31:0]      scratch_q, scratch_d;
   logic             wren_q, wren_d;
   logic             int_clr_q, int_clr_d;
   logic [1:0]       bresp_q, bresp_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       rresp_q, rresp_d;

   logic             aw_hs, w_hs, ar_hs;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [31:0]      wr_data;
   logic [3:0]       wr_strb;
   logic             unused_addr_lsbs;

   // Byte offset within a word never selects a register.
   assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

   assign s_awready = (w_state_q == W_IDLE) && !aw_held_q;
   assign s_wready  = (w_state_q == W_IDLE) && !w_held_q;
   assign s_arready = (r_state_q == R_IDLE);
   assign aw_hs     = s_awvalid && s_awready;
   assign w_hs      = s_wvalid && s_wready;
   assign ar_hs     = s_arvalid && s_arready;

   // A beat arriving this cycle is used directly, otherwise the captured one.
   assign wr_idx  = aw_held_q ? awidx_q : s_awaddr[ADDR_W-1:2];
   assign wr_data = w_held_q  ? wdata_q : s_wdata;
   assign wr_strb = w_held_q  ? wstrb_q : s_wstrb;
   assign rd_idx  = s_araddr[ADDR_W-1:2];

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path through the cases can infer a latch.
      w_state_d = w_state_q;
      aw_held_d = aw_held_q || aw_hs;
      w_held_d  = w_held_q || w_hs;
      div_d     = div_q;
      scratch_d = scratch_q;
      bresp_d   = bresp_q;
      wren_d    = 1'b0;
      int_clr_d = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
               w_state_d = W_RESP;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = RESP_OKAY;
               case (wr_idx)
                  IDX_CTRL: begin
                     if (wr_strb[0]) div_d[7:0]  = wr_data[7:0];
                     if (wr_strb[1]) div_d[11:8] = wr_data[11:8];
                     wren_d = wr_strb[0] || wr_strb[1];
                  end
                  IDX_INTCLR: int_clr_d = wr_strb[0] && wr_data[0];
                  IDX_SCRATCH: begin
                     for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                     end
                  end
                  IDX_INTCNT, IDX_STATUS, IDX_ID: begin
                  end
                  default: bresp_d = RESP_SLVERR;
               endcase
            end
         end
         W_RESP: begin
            if (s_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               rresp_d   = RESP_OKAY;
               case (rd_idx)
                  IDX_CTRL:    rdata_d = {20'd0, div_q};
                  IDX_INTCLR:  rdata_d = 32'd0;
                  IDX_INTCNT:  rdata_d = int_cnt_i;
                  IDX_STATUS:  rdata_d = {30'd0, led_int_i, led_i};
                  IDX_SCRATCH: rdata_d = scratch_q;
                  IDX_ID:      rdata_d = BLK_ID;
                  default: begin
                     rdata_d = 32'd0;
                     rresp_d = RESP_SLVERR;
                  end
               endcase
            end
         end
         R_DATA: begin
            if (s_rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk100) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         div_q     <= '0;
         scratch_q <= '0;
         wren_q    <= 1'b0;
         int_clr_q <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         div_q     <= div_d;
         scratch_q <= scratch_d;
         wren_q    <= wren_d;
         int_clr_q <= int_clr_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // NOTE: capture registers carry no reset; the held flags gate every use of them.
   always_ff @(posedge clk100) begin
      if (aw_hs) awidx_q <= s_awaddr[ADDR_W-1:2];
      if (w_hs) begin
         wdata_q <= s_wdata;
         wstrb_q <= s_wstrb;
      end
   end

   assign s_bvalid  = (w_state_q == W_RESP);
   assign s_bresp   = bresp_q;
   assign s_rvalid  = (r_state_q == R_DATA);
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign div_o     = div_q;
   assign wren_o    = wren_q;
   assign int_clr_o = int_clr_q;

endmodule

// File: doc/led_ctrl_regs.md
LED_CTRL_REGS -- requirements
Module: led_ctrl_regs

Interface
REQ-001 Parameter ADDR_W, default 6, meaning AXI4-Lite byte address width.
REQ-002 Parameter BLK_ID, default 32'h4C45_4431, meaning constant returned by the ID register.
REQ-003 clk100  in  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_awaddr in ADDR_W, s_awvalid in 1, s_awready out 1: write-address channel.
REQ-006 s_wdata in 32, s_wstrb in 4, s_wvalid in 1, s_wready out 1: write-data channel.
REQ-007 s_bresp out 2, s_bvalid out 1, s_bready in 1: write-response channel.
REQ-008 s_araddr in ADDR_W, s_arvalid in 1, s_arready out 1: read-address channel.
REQ-009 s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1: read-data channel.
REQ-010 div_o out 12: LED divider value to the downstream LED counter.
REQ-011 wren_o out 1: one-cycle pulse that restarts the downstream counter.
REQ-012 int_clr_o out 1: one-cycle pulse that clears the downstream interrupt latch and count.
REQ-013 int_cnt_i in 32, led_i in 1, led_int_i in 1: status from the LED counter.

Function
REQ-014 Register map (word offsets, addr[1:0] ignored): 0x00 CTRL RW, div in bits [11:0], bits [31:12] read 0; 0x04 INTCLR W-only, reads 0; 0x08 INTCNT RO = int_cnt_i; 0x0C STATUS RO, bit0 = led_i, bit1 = led_int_i; 0x10 SCRATCH RW 32-bit; 0x14 ID RO = BLK_ID.
REQ-015 Write FSM states: W_IDLE, W_RESP.
REQ-016 In W_IDLE: s_awready=1 until AW is captured; s_wready=1 until W is captured; AW and W are accepted in any order or in the same cycle.
REQ-017 Once both AW and W are held, the register update occurs in that cycle and the FSM enters W_RESP with s_bvalid=1 on the next cycle.
REQ-018 In W_RESP: s_awready=s_wready=0; s_bvalid and s_bresp hold until s_bready=1, then the FSM returns to W_IDLE.
REQ-019 Writes honour s_wstrb per byte lane; a CTRL write with no strobe on lanes 0-1 leaves div unchanged and does not pulse wren_o.
REQ-020 A CTRL write with s_wstrb[0] or s_wstrb[1] set updates div_o and asserts wren_o for exactly one cycle, in the cycle after the update.
REQ-021 An INTCLR write with s_wstrb[0]=1 and wdata[0]=1 asserts int_clr_o for exactly one cycle; wdata[0]=0 has no effect.
REQ-022 Writes to RO offsets are ignored and respond OKAY (2'b00); writes to unmapped offsets are ignored and respond SLVERR (2'b10).
REQ-023 Read FSM states: R_IDLE (s_arready=1) and R_DATA; an AR handshake in R_IDLE samples the addressed data and moves to R_DATA.
REQ-024 In R_DATA: s_rvalid=1; s_rdata and s_rresp are stable until s_rready=1, then the FSM returns to R_IDLE; read latency is 1 cycle from AR handshake to s_rvalid.
REQ-025 Unmapped reads return 0 with SLVERR; mapped reads return OKAY.
REQ-026 Read and write FSMs are independent; a same-cycle read of CTRL during a CTRL write returns the pre-write value.
REQ-027 RO values are sampled at the AR handshake cycle; later changes to int_cnt_i are not reflected in the held s_rdata.

Reset
REQ-028 On rst: write FSM = W_IDLE, read FSM = R_IDLE; AW/W capture flags cleared.
REQ-029 Reset values: div_o=0, SCRATCH=0, wren_o=0, int_clr_o=0, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0.
REQ-030 Reset asserted mid-transaction abandons it without a response; s_awready, s_wready and s_arready equal 1 in the first cycle after reset deasserts.

Structure
REQ-031 Package led_regs_pkg holds the offset localparams, the RESP_OKAY/RESP_SLVERR codes and the write/read state enum typedefs.
REQ-032 No sub-module; the block is a single module that instantiates nothing.

Verification
REQ-033 After reset, read 0x14 -> rdata=32'h4C45_4431, rresp=OKAY; read 0x00 -> 0.
REQ-034 Write 0x00=32'hFFFF_F02B, strb=4'hF -> div_o=12'h02B, one-cycle wren_o pulse; readback of 0x00 returns 32'h0000_002B.
REQ-035 W presented 3 cycles before AW -> single bvalid after AW accepted; bvalid held across 5 cycles of bready=0, then cleared.
REQ-036 Write 0x04=1 -> int_clr_o pulses 1 cycle; write 0x04=0 -> no pulse.
REQ-037 Read 0x08 with int_cnt_i=32'd17, holding rready=0 while int_cnt_i changes to 18 -> rdata stays 17.
REQ-038 Write and read 0x3C -> bresp=SLVERR, rdata=0, rresp=SLVERR; no output changes.
